// File: rtl/mult_div_if.sv
// Request/result bundle between a requester (master) and the multiply/divide unit (slave).
// A request is accepted on a rising edge only when start=1 and busy=0; there is no ready
// back-pressure: a request presented while busy=1 is dropped, never queued or retried.
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             state_dbg;

   modport master (
      output start, md_op, A, B,
      input  busy, hi, lo, state_dbg
   );

   modport slave (
      input  start, md_op, A, B,
      output busy, hi, lo, state_dbg
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus
// single-cycle MTHI/MTLO. Results land in HI/LO only on the final busy cycle.
module mult_div_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mult_div_if.slave  bus
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic               op_is_mult;
   logic               op_is_signed;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] product;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic               div_by_zero;

   // Result datapath works only from latched operands, so input changes during busy are harmless.
   always_comb begin
      op_is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);
      op_is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

      a_ext   = op_is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      b_ext   = op_is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      product = a_ext * b_ext;

      // Signed divide via magnitudes; the most-negative / -1 case wraps back to most-negative.
      a_neg       = op_is_signed && a_q[WIDTH-1];
      b_neg       = op_is_signed && b_q[WIDTH-1];
      a_mag       = a_neg ? (WIDTH'(0) - a_q) : a_q;
      b_mag       = b_neg ? (WIDTH'(0) - b_q) : b_q;
      div_by_zero = (b_q == '0);
      divisor     = div_by_zero ? WIDTH'(1) : b_mag;
      q_mag       = a_mag / divisor;
      r_mag       = a_mag % divisor;
      quotient    = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
      remainder   = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.md_op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_q   <= bus.md_op;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        cnt    <= ((bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU)) ? MULT_N : DIV_N;
                        busy_q <= 1'b1;
                        state  <= RUN;
                     end
                     OP_MTHI: hi_q <= bus.A;
                     OP_MTLO: lo_q <= bus.A;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // Count of 1 marks the final busy cycle: commit and release on this edge.
               if (cnt == CNT_W'(1)) begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
                  if (op_is_mult) begin
                     hi_q <= product[2*WIDTH-1:WIDTH];
                     lo_q <= product[WIDTH-1:0];
                  end else if (!div_by_zero) begin
                     hi_q <= remainder;
                     lo_q <= quotient;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.state_dbg = (state == RUN);

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal range 2..64.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration for multiply ops, >=1.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration for divide ops, >=1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request strobe; qualifies md_op, A, B for one cycle.
REQ-007 md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE.
REQ-008 A  input  WIDTH  operand 1 (multiplicand/dividend/MTHI-MTLO data).
REQ-009 B  input  WIDTH  operand 2 (multiplier/divisor).
REQ-010 busy  output  1  high while a multiply/divide is in flight.
REQ-011 hi  output  WIDTH  HI register, registered.
REQ-012 lo  output  WIDTH  LO register, registered.

Function
REQ-013 Request accepted at an edge only if start=1, busy=0, reset=0 and md_op in 1..6; otherwise no state change.
REQ-014 start with busy=1 ignored entirely; no queuing, operands of the in-flight op unaffected.
REQ-015 MULT/MULTU/DIV/DIVU: A, B, op latched at acceptance edge; later input changes have no effect.
REQ-016 Counter loaded with N = MULT_CYCLES (mult) or DIV_CYCLES (div) at acceptance; busy=1 from that edge for exactly N cycles.
REQ-017 At the N-th edge after acceptance: hi/lo updated with result and busy cleared on the same edge; a new request may be accepted at the next edge (back-to-back gap = 0 idle cycles after busy low).
REQ-018 hi/lo hold previous values throughout busy; intermediate results never visible.
REQ-019 States: IDLE (busy=0), RUN (busy=1, counter decrementing); IDLE->RUN on accepted mult/div; RUN->IDLE when counter reaches final cycle.
REQ-020 MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits. MULTU: same, unsigned.
REQ-021 DIV: signed, quotient truncated toward zero into lo, remainder into hi; remainder sign = dividend sign.
REQ-022 DIVU: unsigned quotient into lo, remainder into hi.
REQ-023 Divide by zero (B=0, DIV or DIVU): busy sequence unchanged, hi/lo retain prior values at completion.
REQ-024 Signed overflow DIV (A = most negative, B = -1): lo = most negative value (wrap), hi = 0.
REQ-025 MTHI/MTLO: single-cycle, no busy; hi (resp. lo) <= A at acceptance edge; other register untouched.
REQ-026 MTHI/MTLO with busy=1 ignored per REQ-014.
REQ-027 Counter width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)); no wrap-around permitted.

Reset
REQ-028 reset=1 at an edge: busy=0, hi=0, lo=0, counter=0, state IDLE, regardless of other inputs.
REQ-029 reset mid-operation aborts the op; no result written; start in the same cycle as reset ignored.
REQ-030 First request acceptable at the first edge with reset=0.

Verification
REQ-031 WIDTH=32 defaults: MULT A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 DIV A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=2 -> lo=3, hi=1.
REQ-033 MTHI A=0x1234 then DIV A=5, B=0 -> hi stays 0x1234, lo unchanged, busy still 10 cycles.
REQ-034 Start MULT, assert start MTLO A=0xAA and change A/B during busy -> MTLO dropped, product reflects latched operands.
REQ-035 Start DIVU, assert reset at busy cycle 4 -> next edge busy=0, hi=lo=0; new MULT A=3, B=4 accepted next cycle -> lo=12, hi=0.
REQ-036 DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0; repeat with WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3 (A=0x80, B=0xFF -> lo=0x80, hi=0).
